// File: rtl/product_accumulator.sv
// product_accumulator: consumer end of the multiplier product stream.
// Unpacks 16-bit products (mode 0) or two packed 8-bit products (mode 1),
// sums them per lane until a beat tagged last, then holds the group result
// on a valid/ready output until it is taken.
// Optional feature macro: PRODUCT_ACC_SAT_EN (lanes clamp on overflow
// instead of wrapping; out_ovf is set either way).
module product_accumulator #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [15:0]        in_prod,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_mode,
  output logic [2*ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_ovf,
  output logic               out_err
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [ACC_W-1:0]   acc0_q, acc0_d;
  logic [ACC_W-1:0]   acc1_q, acc1_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  logic               accept;
  logic               eff_mode;
  logic [ACC_W-1:0]   base0, base1, add0, add1, lane0, lane1;
  logic [ACC_W:0]     sum0, sum1;

  // Lane adders: first beat of a group loads over a zero base with the
  // incoming mode; later beats add to the running lanes with the latched mode.
  always_comb begin
    eff_mode = (state_q == IDLE) ? in_mode : mode_q;
    base0    = (state_q == IDLE) ? '0 : acc0_q;
    base1    = (state_q == IDLE) ? '0 : acc1_q;
    add0     = eff_mode ? ACC_W'(in_prod[7:0]) : ACC_W'(in_prod);
    add1     = eff_mode ? ACC_W'(in_prod[15:8]) : '0;
    sum0     = {1'b0, base0} + {1'b0, add0};
    sum1     = {1'b0, base1} + {1'b0, add1};
`ifdef PRODUCT_ACC_SAT_EN
    lane0    = sum0[ACC_W] ? '1 : sum0[ACC_W-1:0];
    lane1    = sum1[ACC_W] ? '1 : sum1[ACC_W-1:0];
`else
    lane0    = sum0[ACC_W-1:0];
    lane1    = sum1[ACC_W-1:0];
`endif
  end

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;

  // Next-state and next-value logic for the group FSM.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d  = in_mode;
          acc0_d  = lane0;
          acc1_d  = lane1;
          count_d = CNT_W'(1);
          ovf_d   = sum0[ACC_W] | sum1[ACC_W];
          err_d   = 1'b0;
          state_d = in_last ? HOLD : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc0_d  = lane0;
          acc1_d  = lane1;
          count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
          ovf_d   = ovf_q | sum0[ACC_W] | sum1[ACC_W];
          err_d   = err_q | (in_mode != mode_q);
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          mode_d  = 1'b0;
          acc0_d  = '0;
          acc1_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and group registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign out_mode  = mode_q;
  assign out_acc   = {acc1_q, acc0_q};
  assign out_count = count_q;
  assign out_ovf   = ovf_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 24-bit/8-bit-count instance and a
// 16-bit/2-bit-count instance share one input stream; expected group
// results for each are queued when a group is driven and popped when
// the result appears.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_mode, in_last, out_ready;
  logic [15:0] in_prod;

  logic        r24, v24, m24, ovf24, err24;
  logic [47:0] acc24;
  logic [7:0]  cnt24;
  logic        r16, v16, m16, ovf16, err16;
  logic [31:0] acc16;
  logic [1:0]  cnt16;

  typedef struct packed {
    logic        mode;
    logic [47:0] acc;
    logic [7:0]  count;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t q24[$];
  exp_t q16[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(24), .CNT_W(8)) dut24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r24),
    .in_mode(in_mode), .in_prod(in_prod), .in_last(in_last),
    .out_valid(v24), .out_ready(out_ready), .out_mode(m24),
    .out_acc(acc24), .out_count(cnt24), .out_ovf(ovf24), .out_err(err24)
  );

  product_accumulator #(.ACC_W(16), .CNT_W(2)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r16),
    .in_mode(in_mode), .in_prod(in_prod), .in_last(in_last),
    .out_valid(v16), .out_ready(out_ready), .out_mode(m16),
    .out_acc(acc16), .out_count(cnt16), .out_ovf(ovf16), .out_err(err16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic mode, input logic [47:0] acc,
                              input logic [7:0] count, input logic ovf, input logic err);
    exp_t e;
    e.mode = mode; e.acc = acc; e.count = count; e.ovf = ovf; e.err = err;
    return e;
  endfunction

  task automatic send_beat(input logic mode, input logic [15:0] prod, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = mode;
    in_prod  = prod;
    in_last  = last;
    chk("beat_ready", {r24, r16}, 2'b11);
    @(posedge clk);
  endtask

  task automatic check_idle_clean(input string tag);
    chk({tag, "_valid"}, {v24, v16}, 2'b00);
    chk({tag, "_ready"}, {r24, r16}, 2'b11);
    chk({tag, "_acc24"}, acc24, 0);
    chk({tag, "_acc16"}, acc16, 0);
    chk({tag, "_cnt"}, {cnt24, cnt16}, 0);
    chk({tag, "_flags"}, {m24, ovf24, err24, m16, ovf16, err16}, 0);
  endtask

  // Called right after the edge that accepts the last beat of a group.
  task automatic check_result(input string tag, input int unsigned hold_cycles);
    exp_t e24, e16;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_latency_valid"}, {v24, v16}, 2'b11);
    if (q24.size() == 0 || q16.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 1, 0);
      return;
    end
    e24 = q24.pop_front();
    e16 = q16.pop_front();
    chk({tag, "_mode24"}, m24, e24.mode);
    chk({tag, "_acc24"}, acc24, e24.acc);
    chk({tag, "_cnt24"}, cnt24, e24.count);
    chk({tag, "_ovf24"}, ovf24, e24.ovf);
    chk({tag, "_err24"}, err24, e24.err);
    chk({tag, "_mode16"}, m16, e16.mode);
    chk({tag, "_acc16"}, acc16, e16.acc);
    chk({tag, "_cnt16"}, cnt16, e16.count);
    chk({tag, "_ovf16"}, ovf16, e16.ovf);
    chk({tag, "_err16"}, err16, e16.err);
    for (int unsigned i = 0; i < hold_cycles; i++) begin
      in_valid = 1'b1;
      in_prod  = 16'h1111;
      @(negedge clk);
      chk({tag, "_hold_ready"}, {r24, r16}, 2'b00);
      chk({tag, "_hold_valid"}, {v24, v16}, 2'b11);
      chk({tag, "_hold_acc"}, {acc24, acc16}, {e24.acc, e16.acc[31:0]});
      chk({tag, "_hold_cnt"}, {cnt24, cnt16}, {e24.count, e16.count[1:0]});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_idle_clean({tag, "_after"});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_prod = '0;
    in_last = 1'b0; out_ready = 1'b0;
    #12;
    check_idle_clean("reset");
    @(negedge clk);
    rst = 1'b0;

    // Mode 0 group.
    q24.push_back(mk(1'b0, 48'h60, 8'd3, 1'b0, 1'b0));
    q16.push_back(mk(1'b0, 48'h60, 8'd3, 1'b0, 1'b0));
    send_beat(1'b0, 16'h0010, 1'b0);
    send_beat(1'b0, 16'h0020, 1'b0);
    send_beat(1'b0, 16'h0030, 1'b1);
    check_result("m0", 0);

    // Mode 1 group with 5 cycles of backpressure.
    q24.push_back(mk(1'b1, {24'h6, 24'h8}, 8'd2, 1'b0, 1'b0));
    q16.push_back(mk(1'b1, {16'h0, 16'h6, 16'h8}, 8'd2, 1'b0, 1'b0));
    send_beat(1'b1, 16'h0203, 1'b0);
    send_beat(1'b1, 16'h0405, 1'b1);
    check_result("m1_bp", 5);

    // Lane overflow on the 16-bit instance only.
    q24.push_back(mk(1'b0, 48'h10001, 8'd2, 1'b0, 1'b0));
`ifdef PRODUCT_ACC_SAT_EN
    q16.push_back(mk(1'b0, 48'hFFFF, 8'd2, 1'b1, 1'b0));
`else
    q16.push_back(mk(1'b0, 48'h0001, 8'd2, 1'b1, 1'b0));
`endif
    send_beat(1'b0, 16'hFFFF, 1'b0);
    send_beat(1'b0, 16'h0002, 1'b1);
    check_result("ovf", 0);

    // Mode change mid-group: flagged, beat still split with latched mode 1.
    q24.push_back(mk(1'b1, {24'h4, 24'h6}, 8'd2, 1'b0, 1'b1));
    q16.push_back(mk(1'b1, {16'h0, 16'h4, 16'h6}, 8'd2, 1'b0, 1'b1));
    send_beat(1'b1, 16'h0102, 1'b0);
    send_beat(1'b0, 16'h0304, 1'b1);
    check_result("moderr", 0);

    // Asynchronous reset mid-group discards the partial group.
    send_beat(1'b1, 16'h0102, 1'b0);
    send_beat(1'b1, 16'h0304, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle_clean("midrst");
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;

    q24.push_back(mk(1'b0, 48'hF, 8'd2, 1'b0, 1'b0));
    q16.push_back(mk(1'b0, 48'hF, 8'd2, 1'b0, 1'b0));
    send_beat(1'b0, 16'h0007, 1'b0);
    send_beat(1'b0, 16'h0008, 1'b1);
    check_result("post_rst", 0);

    // Five beats: 2-bit count saturates at 3, accumulation continues.
    q24.push_back(mk(1'b1, {24'h5, 24'h5}, 8'd5, 1'b0, 1'b0));
    q16.push_back(mk(1'b1, {16'h0, 16'h5, 16'h5}, 8'd3, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) send_beat(1'b1, 16'h0101, (i == 4));
    check_result("cntsat", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
